// File: rtl/wb_stage_pipe.sv
// Writeback stage with its own M/W pipeline register, sub-word load alignment,
// six-way GRF write-data select and a retired-instruction counter. Sub-word load
// extension is built only when the WB_LOAD_EXT_EN macro is defined.
module wb_stage_pipe #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 32,
  parameter logic [DW-1:0] PC_RESET = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          W_stall,
  input  logic          W_flush,
  input  logic          M_valid,
  input  logic [DW-1:0] M_PC,
  input  logic [AW-1:0] M_GRF_WA,
  input  logic          M_GRF_WE,
  input  logic [2:0]    M_WDSrc,
  input  logic [2:0]    M_LoadType,
  input  logic [1:0]    M_ByteOff,
  input  logic [DW-1:0] M_ALU_Y,
  input  logic [DW-1:0] M_DM_RD,
  input  logic [DW-1:0] M_HI,
  input  logic [DW-1:0] M_LO,
  input  logic [DW-1:0] M_CP0Out,
  output logic          W_valid,
  output logic [DW-1:0] W_PC,
  output logic [AW-1:0] W_GRF_WA,
  output logic          W_GRF_WE,
  output logic [DW-1:0] W_GRF_WD,
  output logic [CW-1:0] W_RetireCnt
);

  localparam logic [2:0] SRC_ALU = 3'd0;
  localparam logic [2:0] SRC_DM  = 3'd1;
  localparam logic [2:0] SRC_PC8 = 3'd2;
  localparam logic [2:0] SRC_CP0 = 3'd3;
  localparam logic [2:0] SRC_HI  = 3'd4;
  localparam logic [2:0] SRC_LO  = 3'd5;

  localparam logic [DW-1:0] PC_STEP = DW'(8);

  logic          r_valid;
  logic [DW-1:0] r_pc;
  logic [AW-1:0] r_wa;
  logic          r_we;
  logic [2:0]    r_wdsrc;
  logic [DW-1:0] r_alu;
  logic [DW-1:0] r_dm;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_cp0;
  logic [CW-1:0] r_retire_cnt;

  logic          w_retire;
  logic [DW-1:0] w_dm_ext;
  logic [DW-1:0] w_wd;

  // Reset and flush both leave a bubble with PC parked at PC_RESET.
  always_ff @(posedge clk) begin
    if (reset || W_flush) begin
      r_valid <= 1'b0;
      r_pc    <= PC_RESET;
      r_wa    <= '0;
      r_we    <= 1'b0;
      r_wdsrc <= SRC_ALU;
      r_alu   <= '0;
      r_dm    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cp0   <= '0;
    end else if (!W_stall) begin
      r_valid <= M_valid;
      r_pc    <= M_PC;
      r_wa    <= M_GRF_WA;
      r_we    <= M_GRF_WE;
      r_wdsrc <= M_WDSrc;
      r_alu   <= M_ALU_Y;
      r_dm    <= M_DM_RD;
      r_hi    <= M_HI;
      r_lo    <= M_LO;
      r_cp0   <= M_CP0Out;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] r_loadtype;
  logic [1:0] r_byteoff;
  logic [7:0]  w_byte_lane [4];
  logic [15:0] w_half_lane [2];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_ff @(posedge clk) begin
    if (reset || W_flush) begin
      r_loadtype <= 3'd0;
      r_byteoff  <= 2'd0;
    end else if (!W_stall) begin
      r_loadtype <= M_LoadType;
      r_byteoff  <= M_ByteOff;
    end
  end

  // Lanes that fall outside a narrow datapath read as zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    if (8 * gi + 8 <= DW) begin : g_in
      assign w_byte_lane[gi] = r_dm[8*gi +: 8];
    end else begin : g_out
      assign w_byte_lane[gi] = 8'd0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
    if (16 * gi + 16 <= DW) begin : g_in
      assign w_half_lane[gi] = r_dm[16*gi +: 16];
    end else begin : g_out
      assign w_half_lane[gi] = 16'd0;
    end
  end

  assign w_byte = w_byte_lane[r_byteoff];
  assign w_half = w_half_lane[r_byteoff[1]];

  always_comb begin
    w_dm_ext = r_dm;
    case (r_loadtype)
      3'd1: w_dm_ext = {{(DW-8){1'b0}}, w_byte};
      3'd2: w_dm_ext = {{(DW-8){w_byte[7]}}, w_byte};
      3'd3: w_dm_ext = {{(DW-16){1'b0}}, w_half};
      3'd4: w_dm_ext = {{(DW-16){w_half[15]}}, w_half};
      default: w_dm_ext = r_dm;
    endcase
  end
`else
  logic w_unused_load;

  assign w_unused_load = ^{M_LoadType, M_ByteOff};
  assign w_dm_ext      = r_dm;
`endif

  always_comb begin
    w_wd = '0;
    case (r_wdsrc)
      SRC_ALU: w_wd = r_alu;
      SRC_DM:  w_wd = w_dm_ext;
      SRC_PC8: w_wd = r_pc + PC_STEP;
      SRC_CP0: w_wd = r_cp0;
      SRC_HI:  w_wd = r_hi;
      SRC_LO:  w_wd = r_lo;
      default: w_wd = '0;
    endcase
  end

  assign w_retire = r_valid && !W_stall && !W_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + CW'(1);
    end
  end

  assign W_valid     = r_valid;
  assign W_PC        = r_pc;
  assign W_GRF_WA    = r_wa;
  assign W_GRF_WE    = r_we && r_valid && (r_wa != '0);
  assign W_GRF_WD    = w_wd;
  assign W_RetireCnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: directed vectors push expectations, a
// negedge monitor pops and compares. A CW=4 copy checks counter wrap.
module tb_wb_stage_pipe;

  logic        clk;
  logic        reset;
  logic        W_stall;
  logic        W_flush;
  logic        M_valid;
  logic [31:0] M_PC;
  logic [4:0]  M_GRF_WA;
  logic        M_GRF_WE;
  logic [2:0]  M_WDSrc;
  logic [2:0]  M_LoadType;
  logic [1:0]  M_ByteOff;
  logic [31:0] M_ALU_Y;
  logic [31:0] M_DM_RD;
  logic [31:0] M_HI;
  logic [31:0] M_LO;
  logic [31:0] M_CP0Out;

  logic        W_valid;
  logic [31:0] W_PC;
  logic [4:0]  W_GRF_WA;
  logic        W_GRF_WE;
  logic [31:0] W_GRF_WD;
  logic [31:0] W_RetireCnt;

  logic        c4_valid;
  logic [31:0] c4_pc;
  logic [4:0]  c4_wa;
  logic        c4_we;
  logic [31:0] c4_wd;
  logic [3:0]  c4_cnt;

  wb_stage_pipe dut (
    .clk(clk), .reset(reset), .W_stall(W_stall), .W_flush(W_flush),
    .M_valid(M_valid), .M_PC(M_PC), .M_GRF_WA(M_GRF_WA), .M_GRF_WE(M_GRF_WE),
    .M_WDSrc(M_WDSrc), .M_LoadType(M_LoadType), .M_ByteOff(M_ByteOff),
    .M_ALU_Y(M_ALU_Y), .M_DM_RD(M_DM_RD), .M_HI(M_HI), .M_LO(M_LO), .M_CP0Out(M_CP0Out),
    .W_valid(W_valid), .W_PC(W_PC), .W_GRF_WA(W_GRF_WA), .W_GRF_WE(W_GRF_WE),
    .W_GRF_WD(W_GRF_WD), .W_RetireCnt(W_RetireCnt)
  );

  wb_stage_pipe #(.CW(4)) dut_c4 (
    .clk(clk), .reset(reset), .W_stall(W_stall), .W_flush(W_flush),
    .M_valid(M_valid), .M_PC(M_PC), .M_GRF_WA(M_GRF_WA), .M_GRF_WE(M_GRF_WE),
    .M_WDSrc(M_WDSrc), .M_LoadType(M_LoadType), .M_ByteOff(M_ByteOff),
    .M_ALU_Y(M_ALU_Y), .M_DM_RD(M_DM_RD), .M_HI(M_HI), .M_LO(M_LO), .M_CP0Out(M_CP0Out),
    .W_valid(c4_valid), .W_PC(c4_pc), .W_GRF_WA(c4_wa), .W_GRF_WE(c4_we),
    .W_GRF_WD(c4_wd), .W_RetireCnt(c4_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    bit          valid;
    logic [31:0] pc;
    logic [4:0]  wa;
    bit          we;
    logic [31:0] wd;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   cur_valid = 1'b0;
  logic [31:0] exp_cnt = 32'd0;

  localparam logic [31:0] DM_C = 32'h80FF7F01;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
    end
  endtask

  // Monitor: compare every expectation that targets the current cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (q.size() != 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      if (e.cyc < cyc_cnt) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s.late: checked at cycle %0d expected cycle %0d", e.nm, cyc_cnt, e.cyc);
      end else begin
        chk(e.nm, "valid", {31'd0, W_valid}, {31'd0, e.valid});
        chk(e.nm, "pc", W_PC, e.pc);
        chk(e.nm, "wa", {27'd0, W_GRF_WA}, {27'd0, e.wa});
        chk(e.nm, "we", {31'd0, W_GRF_WE}, {31'd0, e.we});
        chk(e.nm, "wd", W_GRF_WD, e.wd);
        chk(e.nm, "cnt", W_RetireCnt, e.cnt);
        chk(e.nm, "cnt4", {28'd0, c4_cnt}, {28'd0, e.cnt[3:0]});
      end
      $display("txn %-12s cyc=%0d valid=%0b pc=%h wa=%0d we=%0b wd=%h cnt=%0d cnt4=%0d",
               e.nm, cyc_cnt, W_valid, W_PC, W_GRF_WA, W_GRF_WE, W_GRF_WD, W_RetireCnt, c4_cnt);
    end
  end

  task automatic setm(input bit v, input logic [31:0] pc, input logic [4:0] wa, input bit we,
                      input logic [2:0] src, input logic [2:0] lt, input logic [1:0] off,
                      input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] hi,
                      input logic [31:0] lo, input logic [31:0] cp0);
    M_valid = v; M_PC = pc; M_GRF_WA = wa; M_GRF_WE = we; M_WDSrc = src;
    M_LoadType = lt; M_ByteOff = off; M_ALU_Y = alu; M_DM_RD = dm;
    M_HI = hi; M_LO = lo; M_CP0Out = cp0;
  endtask

  // Drive control for one edge and queue what W must show after that edge.
  task automatic step(input string nm, input bit rst, input bit stall, input bit flush,
                      input bit ev, input logic [31:0] epc, input logic [4:0] ewa,
                      input bit ewe, input logic [31:0] ewd);
    exp_t e;
    reset = rst; W_stall = stall; W_flush = flush;
    if (rst) exp_cnt = 32'd0;
    else if (cur_valid && !stall && !flush) exp_cnt = exp_cnt + 32'd1;
    cur_valid = ev;
    e.cyc = cyc_cnt + 1; e.nm = nm; e.valid = ev; e.pc = epc; e.wa = ewa;
    e.we = ewe; e.wd = ewd; e.cnt = exp_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ld(input logic [31:0] ext);
`ifdef WB_LOAD_EXT_EN
    return ext;
`else
    return (ext == ext) ? DM_C : DM_C;
`endif
  endfunction

  task automatic load(input string nm, input logic [2:0] lt, input logic [1:0] off, input logic [31:0] ext);
    setm(1, 32'h0000_0500, 5'd3, 1, 3'd1, lt, off, 32'hDEADBEEF, DM_C, 32'h0, 32'h0, 32'h0);
    step(nm, 0, 0, 0, 1, 32'h0000_0500, 5'd3, 1, ld(ext));
  endtask

  initial begin
    reset = 1'b1; W_stall = 1'b0; W_flush = 1'b0;
    // Reset with random M bundle
    for (int i = 0; i < 2; i++) begin
      setm(1, $urandom, 5'($urandom), 1, 3'($urandom), 3'($urandom), 2'($urandom),
           $urandom, $urandom, $urandom, $urandom, $urandom);
      step("reset", 1, 0, 0, 0, 32'h0000_3000, 5'd0, 0, 32'h0);
    end
    setm(1, 32'h0000_0400, 5'd8, 1, 3'd0, 3'd0, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0);
    step("alu_wr", 0, 0, 0, 1, 32'h0000_0400, 5'd8, 1, 32'h1234);
    setm(0, 32'h0, 5'd0, 0, 3'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step("bubble", 0, 0, 0, 0, 32'h0, 5'd0, 0, 32'h0);

    load("lb_off0", 3'd2, 2'd0, 32'h00000001);
    load("lb_off1", 3'd2, 2'd1, 32'h0000007F);
    load("lb_off2", 3'd2, 2'd2, 32'hFFFFFFFF);
    load("lb_off3", 3'd2, 2'd3, 32'hFFFFFF80);
    load("lbu_off3", 3'd1, 2'd3, 32'h00000080);
    load("lhu_off2", 3'd3, 2'd2, 32'h000080FF);
    load("lh_off2", 3'd4, 2'd2, 32'hFFFF80FF);
    load("lh_off0", 3'd4, 2'd0, 32'h00007F01);
    load("lhu_off3", 3'd3, 2'd3, 32'h000080FF);
    load("lw", 3'd0, 2'd2, DM_C);
    load("lt6", 3'd6, 2'd1, DM_C);

    // Stall holds a captured write, then stall+flush gives a bubble
    setm(1, 32'h0000_0200, 5'd9, 1, 3'd0, 3'd0, 2'd0, 32'hA5A5, 32'h0, 32'h0, 32'h0, 32'h0);
    step("cap_a5", 0, 0, 0, 1, 32'h0000_0200, 5'd9, 1, 32'hA5A5);
    for (int i = 0; i < 3; i++) begin
      setm(1, 32'h0000_0300 + i, 5'd10, 1, 3'd0, 3'd0, 2'd0, 32'h1111, 32'h0, 32'h0, 32'h0, 32'h0);
      step("stall", 0, 1, 0, 1, 32'h0000_0200, 5'd9, 1, 32'hA5A5);
    end
    step("stall_flush", 0, 1, 1, 0, 32'h0000_3000, 5'd0, 0, 32'h0);

    // Source select and write qualification
    setm(1, 32'h0000_0600, 5'd0, 1, 3'd0, 3'd0, 2'd0, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0);
    step("wa_zero", 0, 0, 0, 1, 32'h0000_0600, 5'd0, 0, 32'h55);
    setm(1, 32'hFFFFFFFC, 5'd5, 1, 3'd2, 3'd0, 2'd0, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0);
    step("pc8_wrap", 0, 0, 0, 1, 32'hFFFFFFFC, 5'd5, 1, 32'h00000004);
    setm(1, 32'h0000_0700, 5'd6, 1, 3'd3, 3'd0, 2'd0, 32'h55, 32'h77, 32'h11112222, 32'h33334444, 32'hC0C0C0C0);
    step("src_cp0", 0, 0, 0, 1, 32'h0000_0700, 5'd6, 1, 32'hC0C0C0C0);
    M_WDSrc = 3'd4;
    step("src_hi", 0, 0, 0, 1, 32'h0000_0700, 5'd6, 1, 32'h11112222);
    M_WDSrc = 3'd5;
    step("src_lo", 0, 0, 0, 1, 32'h0000_0700, 5'd6, 1, 32'h33334444);
    M_WDSrc = 3'd6;
    step("src6", 0, 0, 0, 1, 32'h0000_0700, 5'd6, 1, 32'h0);
    M_WDSrc = 3'd7;
    step("src7", 0, 0, 0, 1, 32'h0000_0700, 5'd6, 1, 32'h0);
    setm(0, 32'h0000_0800, 5'd7, 1, 3'd0, 3'd0, 2'd0, 32'h99, 32'h0, 32'h0, 32'h0, 32'h0);
    step("invalid_we", 0, 0, 0, 0, 32'h0000_0800, 5'd7, 0, 32'h99);
    setm(1, 32'h0000_0900, 5'd7, 1, 3'd0, 3'd0, 2'd0, 32'h99, 32'h0, 32'h0, 32'h0, 32'h0);
    step("cap_99", 0, 0, 0, 1, 32'h0000_0900, 5'd7, 1, 32'h99);
    step("flush", 0, 0, 1, 0, 32'h0000_3000, 5'd0, 0, 32'h0);
    step("cap_99b", 0, 0, 0, 1, 32'h0000_0900, 5'd7, 1, 32'h99);
    step("rst_mid", 1, 1, 0, 0, 32'h0000_3000, 5'd0, 0, 32'h0);

    // 17 back-to-back retires
    for (int i = 0; i < 17; i++) begin
      setm(1, 32'h0000_1000 + 32'(4 * i), 5'd1, 1, 3'd0, 3'd0, 2'd0, 32'(i), 32'h0, 32'h0, 32'h0, 32'h0);
      step("retire", 0, 0, 0, 1, 32'h0000_1000 + 32'(4 * i), 5'd1, 1, 32'(i));
    end
    setm(0, 32'h0, 5'd0, 0, 3'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step("wrap_done", 0, 0, 0, 0, 32'h0, 5'd0, 0, 32'h0);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised writeback stage with its own M/W pipeline register. It captures the memory-stage result bundle, applies stall and flush control, and aligns and sign- or zero-extends sub-word loads. It selects the register-file write data from six sources and counts retired instructions. It sits between the memory stage and the GRF, and its `W_GRF_WA`/`W_GRF_WE`/`W_GRF_WD` outputs also serve as the W-level forwarding source for the hazard unit.

## Interface
- `DW`, 32: datapath width; must be a multiple of 16.
- `AW`, 5: GRF address width.
- `CW`, 32: retire-counter width.
- `PC_RESET`, 32'h0000_3000: `W_PC` value after reset/flush.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `W_stall` in 1: hold the W register contents.
- `W_flush` in 1: insert a bubble (exception/eret).
- `M_valid` in 1: M bundle holds a real instruction.
- `M_PC` in DW: PC of the M instruction.
- `M_GRF_WA` in AW: destination register.
- `M_GRF_WE` in 1: instruction writes the GRF.
- `M_WDSrc` in 3: 0 ALU, 1 DM, 2 PC+8, 3 CP0, 4 HI, 5 LO.
- `M_LoadType` in 3: 0 word, 1 lbu, 2 lb, 3 lhu, 4 lh.
- `M_ByteOff` in 2: low address bits of the load.
- `M_ALU_Y`, `M_DM_RD`, `M_HI`, `M_LO`, `M_CP0Out` in DW each: source values.
- `W_valid` out 1: W holds a real instruction.
- `W_PC` out DW: registered PC.
- `W_GRF_WA` out AW: write address.
- `W_GRF_WE` out 1: qualified write enable.
- `W_GRF_WD` out DW: write data.
- `W_RetireCnt` out CW: count of retired instructions.

## Operation
- The W register holds `valid`, `PC`, `WA`, `WE`, `WDSrc`, `LoadType`, `ByteOff` and the five data values.
- Per-edge priority: `reset` > `W_flush` > `W_stall` > capture.
  - Reset and flush clear valid, WE, WA, WDSrc, LoadType, ByteOff and all data to 0, and set PC to `PC_RESET`.
  - Stall holds every field.
  - Capture loads the M bundle.
- `W_GRF_WE` = reg_WE & reg_valid & (reg_WA != 0). A bubble never writes, and writes to $0 are always suppressed.
- Load extension applies only when WDSrc=1:
  - Byte lane = `DM_RD[8*ByteOff +: 8]`.
  - Half lane = `DM_RD[16*ByteOff[1] +: 16]`.
  - lbu/lhu zero-extend to DW; lb/lh sign-extend.
  - Word and LoadType values 5–7 pass `DM_RD` unchanged.
  - Misaligned halfword loads (ByteOff[0]=1) are trapped upstream; this block ignores ByteOff[0] for halfwords.
- Write-data mux: `W_GRF_WD` = ALU, extended DM, PC+8 (mod 2^DW), CP0, HI, or LO according to WDSrc. WDSrc 6–7 yields 0, never Z or X.
- `W_RetireCnt` increments by 1 on each edge where `W_valid`=1, `W_stall`=0 and `W_flush`=0. It wraps to 0 after 2^CW−1 and resets to 0.

## Timing
- Latency: M bundle at edge N appears on W outputs after edge N; `W_GRF_WD` is combinational from registered state in the same cycle.
- The GRF samples `W_GRF_WD` at edge N+1; same-cycle GRF read bypass is the GRF's responsibility.
- Stall held for k cycles: outputs are constant for k cycles and the counter does not increment.
- Stall and flush together: flush wins and the counter does not increment.
- Reset asserted mid-stream: state clears on the next edge regardless of stall/flush; the counter goes to 0.
- Reset values of every output:
  - `W_valid`=0, `W_PC`=`PC_RESET`, `W_GRF_WA`=0, `W_GRF_WE`=0, `W_RetireCnt`=0.
  - `W_GRF_WD`=0, because the ALU field is cleared and WDSrc=0.

## Configuration
- `WB_LOAD_EXT_EN` defined: sub-word load alignment and extension as above.
- `WB_LOAD_EXT_EN` undefined:
  - LoadType and ByteOff registers are not built.
  - WDSrc=1 passes `DM_RD` raw.
  - The port list is unchanged and those inputs are ignored.

## Test plan
- **Reset:** reset=1 for 2 cycles with random M inputs → all outputs at reset values; release, capture ALU write WA=8, ALU_Y=0x1234 → next cycle WE=1, WD=0x1234, then counter=1 after the following edge.
- **Byte load:** DM_RD=0x80FF7F01, lb at ByteOff 0/1/2/3 → WD = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
- **Halfword load:** same DM_RD, lhu off 2 → 0x000080FF; lh off 2 → 0xFFFF80FF; lh off 0 → 0x00007F01.
- **Stall then flush:** stall for 3 cycles with a captured write → outputs constant and counter frozen; assert stall and flush together → `W_valid`=0, WE=0, `W_PC`=0x00003000, no increment.
- **Source select:** WA=0 with WE=1 → `W_GRF_WE`=0; WDSrc=2, PC=0xFFFFFFFC → WD=0x00000004; WDSrc=4/5 → HI/LO; WDSrc=7 → WD=0.
- **Counter wrap:** CW=4, 17 back-to-back valid retires → counter reads 1.
